stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Controller that sequences the 100 Hz timebase into a stopwatch. It debounces two push buttons and runs a start/pause/lap/clear state machine. It also maintains a 4-digit BCD count (SS.hh) that feeds the 7-segment scan logic. All logic runs on the system clock; the timebase arrives as a single-cycle tick enable.

Parameters:
DEB_LEN, 4, consecutive 100 Hz samples a button must hold before its debounced level changes (range 2..8)
SEC_MAX, 59, highest seconds value; count wraps from SEC_MAX.99 to 00.00 (range 1..99)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
tick_100hz  input  1  one-clk-wide pulse at 100 Hz; count and debounce enable
btn_start  input  1  raw start/pause button, asynchronous, active-high
btn_lap  input  1  raw lap/clear button, asynchronous, active-high
disp_bcd  output  16  {sec_tens, sec_ones, hund_tens, hund_ones}, 4 bits per digit
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP (display frozen)
wrap  output  1  one-clk pulse when the count rolls SEC_MAX.99 -> 00.00

Behaviour:
- Reset (async, rst_n=0) clears everything: state=IDLE, count=00.00, lap latch=00.00, disp_bcd=16'h0000, running=0, lap_active=0, wrap=0, synchronizers and debounce shift registers all 0.
- Input conditioning, per button:
  - 2-FF synchronizer on clk.
  - On each tick_100hz, the synchronized value shifts into a DEB_LEN-bit register.
  - Debounced level goes to 1 when the register is all-ones and to 0 when it is all-zeros; otherwise it holds.
  - Press pulse (1 clk) fires on the clk cycle after the debounced level rises 0->1. Releases produce no event.
  - A button must therefore be high for DEB_LEN ticks (40 ms at default) to register.
- FSM states and transitions on press pulses:
  - IDLE: start -> RUN. lap is ignored.
  - RUN: start -> PAUSE. lap -> LAP and copies the current count into the lap latch.
  - LAP: start -> PAUSE, display reverts to live count. lap -> RUN, display live.
  - PAUSE: start -> RUN. lap -> IDLE and clears the count to 00.00.
  - Simultaneous start and lap pulses in the same cycle: start wins, lap is discarded.
- Counting:
  - The count advances by 0.01 on tick_100hz when the current (pre-transition) state is RUN or LAP.
  - Digits are BCD:
    - hund_ones wraps 9->0 and carries into hund_tens.
    - hund_tens wraps 9->0 and carries into sec_ones.
    - sec_ones wraps 9->0 and carries into sec_tens.
    - When the seconds value equals SEC_MAX and the hundredths equal 99, the whole count goes to 00.00 and wrap pulses in the same cycle the count updates.
  - No digit ever holds a value above 9.
- Simultaneous tick and transition: if a tick coincides with the RUN->PAUSE pulse, the increment still applies. If a tick coincides with the PAUSE->RUN pulse, no increment happens on that cycle. The RUN->LAP latch captures the pre-increment count.
- Outputs:
  - disp_bcd, running, lap_active and wrap are registered and update 1 clk after the state or count changes.
  - disp_bcd = lap latch in LAP, otherwise the live count.
- Reset mid-operation: immediate return to the reset values. A button held through reset release must be seen as 0 then 1 by the debouncer before it fires, so no spurious press occurs.

Test Plan:
- Reset, then btn_start held for 4 ticks -> one start pulse, state RUN, running=1. After 150 further ticks, disp_bcd=16'h0150.
- Bounce: btn_start toggling every tick for 20 ticks, then low -> no press pulse; state stays IDLE and disp_bcd=16'h0000.
- RUN at 12.34, press lap -> disp_bcd frozen at 16'h1234 and lap_active=1. After 100 ticks the internal count is 13.34 and the display is still 1234. Press lap again -> display shows the live count (13.xx) and lap_active=0.
- Preload by running to 59.99, then one tick -> disp_bcd=16'h0000 and wrap pulses for exactly 1 clk. Repeat with SEC_MAX=9: 09.99 -> 00.00.
- PAUSE at 03.07, then 50 ticks -> count unchanged at 0307. Press lap -> IDLE, 0000. Press start -> RUN. Start and lap pressed on the same cycle while in RUN -> PAUSE, lap latch unchanged.
- Assert rst_n low mid-RUN at 05.55 while holding btn_start, release reset -> all outputs 0, state IDLE, no start pulse until the button is released and pressed again.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounces start and lap buttons, runs the IDLE/RUN/LAP/PAUSE
// state machine and keeps a four-digit BCD SS.hh count for the display scanner.
module stopwatch_ctrl #(
    parameter int DEB_LEN = 4,
    parameter int SEC_MAX = 59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_100hz,
    input  logic        btn_start,
    input  logic        btn_lap,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    localparam logic [3:0] SEC_MAX_T = 4'(SEC_MAX / 10);
    localparam logic [3:0] SEC_MAX_O = 4'(SEC_MAX % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    // Returns {carry, next digit}; any value of 9 or above rolls to 0.
    function automatic logic [4:0] digit_inc(input logic [3:0] d);
        if (d >= 4'd9) return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

    // Returns {wrap, next count} for one 0.01 s step of the SS.hh count.
    function automatic logic [16:0] bcd_step(input logic [15:0] c);
        logic [4:0] ho;
        logic [4:0] ht;
        logic [4:0] so;
        logic [3:0] st;
        if (c[15:12] == SEC_MAX_T && c[11:8] == SEC_MAX_O && c[7:0] == 8'h99)
            return {1'b1, 16'h0000};
        ho = digit_inc(c[3:0]);
        ht = ho[4] ? digit_inc(c[7:4])  : {1'b0, c[7:4]};
        so = ht[4] ? digit_inc(c[11:8]) : {1'b0, c[11:8]};
        st = so[4] ? ((c[15:12] >= 4'd9) ? 4'd0 : c[15:12] + 4'd1) : c[15:12];
        return {1'b0, st, so[3:0], ht[3:0], ho[3:0]};
    endfunction

    logic [1:0]         btn_raw;
    logic [1:0]         meta_p0;
    logic [1:0]         sync_p1;
    logic               vld_p0;
    logic               vld_p1;
    logic [DEB_LEN-1:0] deb_sh   [2];
    logic [DEB_LEN-1:0] sh_next  [2];
    logic [1:0]         deb_lvl;
    logic [1:0]         deb_lvl_q;
    logic [1:0]         armed;
    logic [1:0]         press;
    logic               start_pulse;
    logic               lap_pulse;

    state_t             state;
    state_t             state_nxt;
    logic               lap_capture;
    logic               cnt_clear;
    logic               count_en;
    logic [16:0]        cnt_step;
    logic [15:0]        cnt_p0;
    logic [15:0]        lap_p0;

    assign btn_raw = {btn_lap, btn_start};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sh_next[i] = {deb_sh[i][DEB_LEN-2:0], sync_p1[i]};
        end
    end

    // Synchronizer and debounce stage. vld_p1 marks when sync_p1 holds a real
    // post-reset sample, so a button held through reset never arms its press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0   <= '0;
            sync_p1   <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            deb_lvl   <= '0;
            deb_lvl_q <= '0;
            armed     <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_sh[i] <= '0;
            end
        end else begin
            meta_p0   <= btn_raw;
            sync_p1   <= meta_p0;
            vld_p0    <= 1'b1;
            vld_p1    <= vld_p0;
            deb_lvl_q <= deb_lvl;
            if (tick_100hz) begin
                for (int i = 0; i < 2; i++) begin
                    deb_sh[i] <= sh_next[i];
                    if (&sh_next[i]) begin
                        deb_lvl[i] <= 1'b1;
                    end else if (sh_next[i] == '0) begin
                        deb_lvl[i] <= 1'b0;
                        if (vld_p1) armed[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign press       = deb_lvl & ~deb_lvl_q & armed;
    assign start_pulse = press[0];
    assign lap_pulse   = press[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Start has priority over lap whenever both pulses land together.
    always_comb begin
        state_nxt   = state;
        lap_capture = 1'b0;
        cnt_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse) state_nxt = RUN;
            end
            RUN: begin
                if (start_pulse) begin
                    state_nxt = PAUSE;
                end else if (lap_pulse) begin
                    state_nxt   = LAP;
                    lap_capture = 1'b1;
                end
            end
            LAP: begin
                if (start_pulse)    state_nxt = PAUSE;
                else if (lap_pulse) state_nxt = RUN;
            end
            PAUSE: begin
                if (start_pulse) begin
                    state_nxt = RUN;
                end else if (lap_pulse) begin
                    state_nxt = IDLE;
                    cnt_clear = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign count_en = tick_100hz && (state == RUN || state == LAP);
    assign cnt_step = bcd_step(cnt_p0);

    // Count stage: the latch samples the pre-increment count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
            lap_p0 <= '0;
            wrap   <= 1'b0;
        end else begin
            if (cnt_clear)     cnt_p0 <= '0;
            else if (count_en) cnt_p0 <= cnt_step[15:0];
            if (lap_capture)   lap_p0 <= cnt_p0;
            wrap <= count_en & cnt_step[16];
        end
    end

    // Output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd   <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            disp_bcd   <= (state == LAP) ? lap_p0 : cnt_p0;
            running    <= (state == RUN) || (state == LAP);
            lap_active <= (state == LAP);
        end
    end

endmodule
